// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, start/busy/done handshake.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output ovf_o.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    // state | meaning
    // IDLE  | waiting for start; diff/bout hold the last result
    // RUN   | one bit per edge, LSB first, through the full-subtractor cell
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic             d_bit;
    logic             br_nxt;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    br_d    = bin_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                br_d   = br_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bout_d  = br_nxt;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
                    // overflow = borrow into MSB xor borrow out of MSB
                    ovf_d   = br_q ^ br_nxt;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table plus hand-written
// sequences for ignored start, mid-run reset and back-to-back starts.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         bin_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         bout_o;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .bin_i   (bin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .diff_o  (diff_o),
        .bout_o  (bout_o)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits (sampling on negedges) until done_o, bounded; returns busy cycles seen.
    task automatic wait_done(output int busy_cnt, output bit got);
        busy_cnt = 0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) begin
                got = 1'b1;
                break;
            end
            if (busy_o) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  bc;
        bit  got;
        @(negedge clk);
        a_i = v.a; b_i = v.b; bin_i = v.bin; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_i = ~v.a; b_i = v.a; bin_i = ~v.bin;
        wait_done(bc, got);
        check($sformatf("v%0d done_seen", idx), 32'(got), 32'd1);
        check($sformatf("v%0d busy_cycles", idx), 32'(bc), 32'd8);
        check($sformatf("v%0d busy_at_done", idx), 32'(busy_o), 32'd0);
        check($sformatf("v%0d diff", idx), 32'(diff_o), 32'(v.diff));
        check($sformatf("v%0d bout", idx), 32'(bout_o), 32'(v.bout));
`ifdef SERIAL_SUB_OVF_EN
        check($sformatf("v%0d ovf", idx), 32'(ovf_o), 32'(v.ovf));
`endif
        @(negedge clk);
        check($sformatf("v%0d done_width", idx), 32'(done_o), 32'd0);
        check($sformatf("v%0d diff_hold", idx), 32'(diff_o), 32'(v.diff));
    endtask

    initial begin
        int  bc;
        bit  got;
        int  pulses;
        logic [W-1:0] seen_diff;
        logic         seen_bout;

        vecs[0] = '{a: 8'd100, b: 8'd37,  bin: 1'b0, diff: 8'd63,  bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd9,   bin: 1'b0, diff: 8'hFC,  bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'd0,   b: 8'd0,   bin: 1'b1, diff: 8'd255, bout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 8'd255, b: 8'd255, bin: 1'b0, diff: 8'd0,   bout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'h80,  b: 8'h01,  bin: 1'b0, diff: 8'h7F,  bout: 1'b0, ovf: 1'b1};
        vecs[5] = '{a: 8'h10,  b: 8'h01,  bin: 1'b0, diff: 8'h0F,  bout: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'h7F,  b: 8'hFF,  bin: 1'b0, diff: 8'h80,  bout: 1'b1, ovf: 1'b1};
        vecs[7] = '{a: 8'd200, b: 8'd100, bin: 1'b1, diff: 8'd99,  bout: 1'b0, ovf: 1'b1};
        vecs[8] = '{a: 8'd0,   b: 8'd1,   bin: 1'b0, diff: 8'hFF,  bout: 1'b1, ovf: 1'b0};

        #12;
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst diff", 32'(diff_o), 32'd0);
        check("rst bout", 32'(bout_o), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst ovf", 32'(ovf_o), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // start re-pulsed 3 cycles into RUN must be ignored
        @(negedge clk);
        a_i = 8'd100; b_i = 8'd37; bin_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        a_i = 8'd1; b_i = 8'd1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("ign busy", 32'(busy_o), 32'd1);
        pulses = 0;
        seen_diff = '0;
        seen_bout = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done_o) begin
                pulses++;
                seen_diff = diff_o;
                seen_bout = bout_o;
            end
            @(negedge clk);
        end
        check("ign pulses", 32'(pulses), 32'd1);
        check("ign diff", 32'(seen_diff), 32'd63);
        check("ign bout", 32'(seen_bout), 32'd0);

        // reset 4 cycles into RUN aborts the op
        a_i = 8'd5; b_i = 8'd9; bin_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort done", 32'(done_o), 32'd0);
        check("abort diff", 32'(diff_o), 32'd0);
        check("abort bout", 32'(bout_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (done_o || busy_o) pulses++;
            @(negedge clk);
        end
        check("abort no_done", 32'(pulses), 32'd0);

        // start held high: next op accepted on the edge after done
        a_i = 8'd10; b_i = 8'd3; bin_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        a_i = 8'd20; b_i = 8'd25; bin_i = 1'b1;
        wait_done(bc, got);
        check("b2b first_seen", 32'(got), 32'd1);
        check("b2b first_busy", 32'(bc), 32'd8);
        check("b2b first_diff", 32'(diff_o), 32'd7);
        check("b2b first_bout", 32'(bout_o), 32'd0);
        check("b2b busy_at_done", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("b2b reaccept", 32'(busy_o), 32'd1);
        start_i = 1'b0;
        wait_done(bc, got);
        check("b2b second_seen", 32'(got), 32'd1);
        check("b2b second_diff", 32'(diff_o), 32'd250);
        check("b2b second_bout", 32'(bout_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
